// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - core and peripheral side signals of the interrupt arbiter
interface irq_controller_if #(
  parameter int IRQ_NUM = 16
);
  logic [IRQ_NUM-1:0] irq_req_i;
  logic [31:0]        mie_i;
  logic               exception_i;
  logic               mret_i;
  logic               irq_o;
  logic [31:0]        irq_cause_o;
  logic [IRQ_NUM-1:0] irq_ret_o;
  logic               busy_o;

  modport master (
    output irq_req_i, mie_i, exception_i, mret_i,
    input  irq_o, irq_cause_o, irq_ret_o, busy_o
  );

  modport slave (
    input  irq_req_i, mie_i, exception_i, mret_i,
    output irq_o, irq_cause_o, irq_ret_o, busy_o
  );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched fast-interrupt arbiter feeding the CSR trap path
// Optional IRQ_SYNC_EN: 2-flop synchronizer on irq_req_i ahead of edge detect.
module irq_controller #(
  parameter int          IRQ_NUM    = 16,
  parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
  input logic             clk_i,
  input logic             rstn_i,
  irq_controller_if.slave bus
);
  localparam int          IDX_W    = (IRQ_NUM > 1) ? $clog2(IRQ_NUM) : 1;
  localparam logic [31:0] MIE_MASK = ((32'h1 << IRQ_NUM) - 32'h1) << 16;

  typedef enum logic {IDLE, ISR} state_t;

  state_t             state_q, state_n;
  logic [IRQ_NUM-1:0] req_s, req_q, rise, pending_q, pending_n, enabled;
  logic [IRQ_NUM-1:0] ret_q, ret_n, idx_onehot;
  logic [IDX_W-1:0]   idx_q, idx_n, sel_idx;
  logic               irq_q, irq_n;
  logic [31:0]        cause_q, cause_n;
  logic               unused_mie;

`ifdef IRQ_SYNC_EN
  localparam int ARM_W = 3;
  logic [IRQ_NUM-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= bus.irq_req_i;
      sync_q2 <= sync_q1;
    end
  end
  assign req_s = sync_q2;
`else
  localparam int ARM_W = 1;
  assign req_s = bus.irq_req_i;
`endif

  // Edge detect is armed only once req_q holds a real sample, so levels
  // still held across a reset are not mistaken for new edges.
  logic [ARM_W-1:0] arm_q;

  assign rise       = arm_q[ARM_W-1] ? (req_s & ~req_q) : '0;
  assign enabled    = pending_q & bus.mie_i[16 +: IRQ_NUM];
  assign pending_n  = (pending_q & ~ret_n) | rise;
  assign unused_mie = ^(bus.mie_i & ~MIE_MASK);

  always_comb begin
    sel_idx = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (enabled[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      idx_onehot[i] = (idx_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_n = state_q;
    irq_n   = 1'b0;
    cause_n = cause_q;
    idx_n   = idx_q;
    ret_n   = '0;
    case (state_q)
      IDLE: begin
        if ((|enabled) && !bus.exception_i) begin
          idx_n   = sel_idx;
          irq_n   = 1'b1;
          cause_n = CAUSE_BASE + {{(32 - IDX_W){1'b0}}, sel_idx};
          state_n = ISR;
        end
      end
      ISR: begin
        if (bus.mret_i) begin
          ret_n   = idx_onehot;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      arm_q     <= '0;
      req_q     <= '0;
      pending_q <= '0;
      idx_q     <= '0;
      irq_q     <= 1'b0;
      cause_q   <= '0;
      ret_q     <= '0;
    end else begin
      state_q   <= state_n;
      arm_q     <= (arm_q << 1) | ARM_W'(1);
      req_q     <= req_s;
      pending_q <= pending_n;
      idx_q     <= idx_n;
      irq_q     <= irq_n;
      cause_q   <= cause_n;
      ret_q     <= ret_n;
    end
  end

  assign bus.irq_o       = irq_q;
  assign bus.irq_cause_o = cause_q;
  assign bus.irq_ret_o   = ret_q;
  assign bus.busy_o      = (state_q == ISR);
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed and randomized checks of irq_controller against a rule-level model
module tb_irq_controller;
  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h8000_0010;
`ifdef IRQ_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk = 1'b0;
  logic rstn;

  irq_controller_if #(.IRQ_NUM(N)) bus ();

  irq_controller #(.IRQ_NUM(N), .CAUSE_BASE(BASE)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: request history since reset release, pending set, handler state.
  logic [N-1:0] hist[$];
  int           k;
  logic [N-1:0] m_pend;
  logic         m_busy;
  int           m_idx;
  logic         m_irq;
  logic [31:0]  m_cause;
  logic [N-1:0] m_ret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    k       = 0;
    m_pend  = '0;
    m_busy  = 1'b0;
    m_idx   = 0;
    m_irq   = 1'b0;
    m_cause = '0;
    m_ret   = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] now_l, prev_l, rise, en;
    k++;
    hist.push_back(bus.irq_req_i);
    now_l  = (k > D)     ? hist[k-1-D] : '0;
    prev_l = (k > D + 1) ? hist[k-2-D] : '0;
    rise   = (k >= D + 2) ? (now_l & ~prev_l) : '0;
    m_irq  = 1'b0;
    m_ret  = '0;
    if (m_busy) begin
      if (bus.mret_i) begin
        m_ret[m_idx]  = 1'b1;
        m_pend[m_idx] = 1'b0;
        m_busy        = 1'b0;
      end
    end else begin
      en = m_pend & bus.mie_i[16 +: N];
      if (en != '0 && !bus.exception_i) begin
        m_idx = 0;
        while (!en[m_idx]) m_idx++;
        m_irq   = 1'b1;
        m_cause = BASE + 32'(m_idx);
        m_busy  = 1'b1;
      end
    end
    m_pend = m_pend | rise;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("irq_o", 32'(bus.irq_o), 32'(m_irq));
    check("irq_cause_o", bus.irq_cause_o, m_cause);
    check("irq_ret_o", 32'(bus.irq_ret_o), 32'(m_ret));
    check("busy_o", 32'(bus.busy_o), 32'(m_busy));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_irq(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.irq_o && n < budget);
    check("irq_seen", 32'(bus.irq_o), 32'd1);
  endtask

  task automatic count_irq(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.irq_o) seen++;
    end
  endtask

  task automatic do_mret(input string tag, input logic [N-1:0] exp_ack);
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    check(tag, 32'(bus.irq_ret_o), 32'(exp_ack));
  endtask

  initial begin
    int n, seen;
    rstn            = 1'b0;
    bus.irq_req_i   = '0;
    bus.mie_i       = '0;
    bus.exception_i = 1'b0;
    bus.mret_i      = 1'b0;
    model_reset();
    #12;
    check("rst_irq", 32'(bus.irq_o), 32'd0);
    check("rst_cause", bus.irq_cause_o, 32'd0);
    check("rst_ret", 32'(bus.irq_ret_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    ticks(5);

    // single line
    bus.mie_i        = 32'h0001_0000;
    bus.irq_req_i[0] = 1'b1;
    wait_irq(20, n);
    check("single_latency", 32'(n), 32'(2 + D));
    check("single_cause", bus.irq_cause_o, 32'h8000_0010);
    tick();
    check("single_pulse_width", 32'(bus.irq_o), 32'd0);
    check("single_busy", 32'(bus.busy_o), 32'd1);
    ticks(3);
    do_mret("single_ack", 16'h0001);
    bus.irq_req_i[0] = 1'b0;
    tick();
    check("single_idle", 32'(bus.busy_o), 32'd0);

    // priority
    bus.mie_i     = 32'hFFFF_0000;
    bus.irq_req_i = 16'h0088;
    wait_irq(20, n);
    check("prio_cause_first", bus.irq_cause_o, 32'h8000_0013);
    ticks(2);
    do_mret("prio_ack_first", 16'h0008);
    bus.irq_req_i[3] = 1'b0;
    wait_irq(10, n);
    check("prio_next_latency", 32'(n), 32'd1);
    check("prio_cause_second", bus.irq_cause_o, 32'h8000_0017);
    do_mret("prio_ack_second", 16'h0080);
    bus.irq_req_i = '0;
    ticks(2);

    // masking
    bus.mie_i        = 32'h0;
    bus.irq_req_i[5] = 1'b1;
    count_irq(10 + D, seen);
    check("mask_no_irq", 32'(seen), 32'd0);
    bus.mie_i = 32'h0020_0000;
    wait_irq(10, n);
    check("mask_enable_latency", 32'(n), 32'd1);
    check("mask_cause", bus.irq_cause_o, 32'h8000_0015);
    do_mret("mask_ack", 16'h0020);
    bus.irq_req_i = '0;
    ticks(2);

    // exception blocking and no nesting
    bus.mie_i        = 32'hFFFF_0000;
    bus.irq_req_i[2] = 1'b1;
    ticks(1 + D);
    bus.exception_i = 1'b1;
    count_irq(3, seen);
    check("exc_blocked", 32'(seen), 32'd0);
    bus.exception_i = 1'b0;
    wait_irq(10, n);
    check("exc_release_latency", 32'(n), 32'd1);
    check("exc_cause", bus.irq_cause_o, 32'h8000_0012);
    bus.irq_req_i[1] = 1'b1;
    count_irq(5 + D, seen);
    check("no_nesting", 32'(seen), 32'd0);
    do_mret("exc_ack", 16'h0004);
    wait_irq(10, n);
    check("after_mret_latency", 32'(n), 32'd1);
    check("after_mret_cause", bus.irq_cause_o, 32'h8000_0011);
    do_mret("after_mret_ack", 16'h0002);
    bus.irq_req_i = '0;
    ticks(2);

    // reset mid-ISR, held request, stray mret
    bus.irq_req_i[4] = 1'b1;
    wait_irq(20, n);
    check("rst_isr_latency", 32'(n), 32'(2 + D));
    tick();
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    check("rst_async_irq", 32'(bus.irq_o), 32'd0);
    check("rst_async_cause", bus.irq_cause_o, 32'd0);
    check("rst_async_ret", 32'(bus.irq_ret_o), 32'd0);
    check("rst_async_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    count_irq(10 + D, seen);
    check("rst_no_retrap", 32'(seen), 32'd0);
    do_mret("stray_mret_ack", 16'h0000);
    bus.irq_req_i[4] = 1'b0;
    ticks(2);
    bus.irq_req_i[4] = 1'b1;
    wait_irq(20, n);
    check("rst_new_edge_latency", 32'(n), 32'(2 + D));
    check("rst_new_edge_cause", bus.irq_cause_o, 32'h8000_0014);
    do_mret("rst_new_edge_ack", 16'h0010);
    bus.irq_req_i = '0;
    ticks(2);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 7) == 0)
        bus.irq_req_i = bus.irq_req_i ^ (16'h1 << $urandom_range(0, N - 1));
      if ($urandom_range(0, 49) == 0)
        bus.mie_i = $urandom() | (($urandom_range(0, 1) == 0) ? 32'hFFFF_0000 : 32'h0);
      bus.exception_i = ($urandom_range(0, 7) == 0);
      bus.mret_i = m_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
